// File: rtl/pcpi_cmd_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pcpi_cmd_initiator: buffers host commands, issues them as custom-0 PCPI   |
// | instructions and returns the coprocessor result or a timeout flag.        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module pcpi_cmd_initiator #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [6:0]  OPCODE         = 7'b0001011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_funct3_i,
  input  logic [4:0]  cmd_addr_i,
  input  logic [15:0] cmd_value_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic        resp_wr_o,
  output logic        resp_timeout_o,
  output logic        busy_o,
  output logic        pcpi_valid_o,
  output logic [31:0] pcpi_insn_o,
  input  logic        pcpi_wr_i,
  input  logic [31:0] pcpi_rd_i,
  input  logic        pcpi_wait_i,
  input  logic        pcpi_ready_i
);

  localparam int unsigned c_aw      = $clog2(FIFO_DEPTH);
  localparam int unsigned c_tw      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned c_entry_w = 24;
  localparam logic [c_tw-1:0] c_timeout_last = c_tw'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_REQ   = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [c_tw-1:0]     timer_q, timer_d;
  logic [31:0]         insn_q, insn_d;
  logic                valid_q, valid_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         resp_data_q, resp_data_d;
  logic                resp_wr_q, resp_wr_d;
  logic                resp_to_q, resp_to_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [c_aw:0]        wr_ptr_q, rd_ptr_q;
  logic [c_entry_w-1:0] mem_q [FIFO_DEPTH];
  logic                 fifo_empty, fifo_full, push, pop;
  logic [c_entry_w-1:0] head;

  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                       (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
  assign cmd_ready_o = !rst && !fifo_full;
  assign push        = cmd_valid_i && cmd_ready_o;
  assign head        = mem_q[rd_ptr_q[c_aw-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[c_aw-1:0]] <= {cmd_value_i, cmd_funct3_i, cmd_addr_i};
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    insn_d       = insn_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_wr_d    = resp_wr_q;
    resp_to_d    = resp_to_q;
    pop          = 1'b0;

    if (resp_valid_q && resp_ready_i) begin
      resp_valid_d = 1'b0;
      resp_data_d  = 32'd0;
      resp_wr_d    = 1'b0;
      resp_to_d    = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        // Registered resp_valid blocks issue during the handshake cycle too.
        if (!fifo_empty && !resp_valid_q) begin
          pop     = 1'b1;
          insn_d  = {1'b0, head, OPCODE};
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (pcpi_ready_i) begin
          resp_valid_d = 1'b1;
          resp_data_d  = pcpi_wr_i ? pcpi_rd_i : 32'd0;
          resp_wr_d    = pcpi_wr_i;
          resp_to_d    = 1'b0;
          state_d      = S_GAP;
        end else if (pcpi_wait_i) begin
          timer_d = '0;
        end else if (timer_q == c_timeout_last) begin
          resp_valid_d = 1'b1;
          resp_data_d  = 32'd0;
          resp_wr_d    = 1'b0;
          resp_to_d    = 1'b1;
          state_d      = S_GAP;
        end else begin
          timer_d = timer_q + c_tw'(1);
        end
      end
      S_GAP: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    valid_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      insn_q       <= 32'd0;
      valid_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_wr_q    <= 1'b0;
      resp_to_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      insn_q       <= insn_d;
      valid_q      <= valid_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_wr_q    <= resp_wr_d;
      resp_to_q    <= resp_to_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign pcpi_valid_o   = valid_q;
  assign pcpi_insn_o    = insn_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_data_o    = resp_data_q;
  assign resp_wr_o      = resp_wr_q;
  assign resp_timeout_o = resp_to_q;
  assign busy_o         = !fifo_empty || (state_q != S_IDLE) || resp_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pcpi_cmd_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pcpi_cmd_initiator: directed vector bench for pcpi_cmd_initiator.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_pcpi_cmd_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_funct3;
  logic [4:0]  cmd_addr;
  logic [15:0] cmd_value;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_wr, resp_timeout, busy;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait, pcpi_ready;

  int errors = 0;
  int checks = 0;

  pcpi_cmd_initiator dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_funct3_i   (cmd_funct3),
    .cmd_addr_i     (cmd_addr),
    .cmd_value_i    (cmd_value),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_data_o    (resp_data),
    .resp_wr_o      (resp_wr),
    .resp_timeout_o (resp_timeout),
    .busy_o         (busy),
    .pcpi_valid_o   (pcpi_valid),
    .pcpi_insn_o    (pcpi_insn),
    .pcpi_wr_i      (pcpi_wr),
    .pcpi_rd_i      (pcpi_rd),
    .pcpi_wait_i    (pcpi_wait),
    .pcpi_ready_i   (pcpi_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [4:0]  addr;
    logic [15:0] val;
    int          silent;    // leading cycles with neither wait nor ready
    int          waitc;     // then this many wait cycles
    bit          rdy;       // then ready (1) or silence until timeout (0)
    bit          rdy_wait;  // assert wait together with ready
    logic [31:0] rd;
    bit          wr;
    logic [31:0] e_insn;
    logic [31:0] e_data;
    bit          e_wr;
    bit          e_to;
    int          e_cyc;
  } vec_t;

  vec_t vt [7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int k);
    logic [15:0] v;
    logic [2:0]  f;
    logic [4:0]  a;
    v = 16'h0100 + 16'(k);
    f = 3'(k);
    a = 5'(k);
    return {1'b0, v, f, a, 7'b0001011};
  endfunction

  task automatic clear_pcpi;
    pcpi_ready = 1'b0;
    pcpi_wait  = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = 32'd0;
  endtask

  task automatic do_txn(input vec_t v);
    int n;
    cmd_valid  = 1'b1;
    cmd_funct3 = v.f3;
    cmd_addr   = v.addr;
    cmd_value  = v.val;
    chk("push_ready", {31'd0, cmd_ready}, 32'd1);
    tick;
    cmd_valid = 1'b0;
    tick;
    chk("lat_e1_valid", {31'd0, pcpi_valid}, 32'd0);
    tick;
    chk("lat_e2_valid", {31'd0, pcpi_valid}, 32'd1);
    chk("insn", pcpi_insn, v.e_insn);
    n = 0;
    while (pcpi_valid && n < 100) begin
      n++;
      pcpi_ready = 1'b0;
      pcpi_wait  = 1'b0;
      pcpi_rd    = 32'hBAD0BAD0;
      pcpi_wr    = 1'b1;
      if (n <= v.silent) begin
      end else if (n <= v.silent + v.waitc) begin
        pcpi_wait = 1'b1;
      end else if (v.rdy) begin
        pcpi_ready = 1'b1;
        pcpi_wait  = v.rdy_wait;
        pcpi_rd    = v.rd;
        pcpi_wr    = v.wr;
      end
      tick;
    end
    clear_pcpi();
    chk("valid_cycles", n, v.e_cyc);
    chk("resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("resp_data", resp_data, v.e_data);
    chk("resp_wr", {31'd0, resp_wr}, {31'd0, v.e_wr});
    chk("resp_timeout", {31'd0, resp_timeout}, {31'd0, v.e_to});
    chk("busy_held", {31'd0, busy}, 32'd1);
    tick;
    chk("gap_valid", {31'd0, pcpi_valid}, 32'd0);
    chk("resp_hold", {31'd0, resp_valid}, 32'd1);
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk("resp_cleared", {31'd0, resp_valid}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n, low;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_funct3 = 3'd0; cmd_addr = 5'd0; cmd_value = 16'd0;
    resp_ready = 1'b0;
    clear_pcpi();

    vt[0] = '{3'd0, 5'd0,  16'h0012, 0,  0,  1'b1, 1'b0, 32'h000000A5, 1'b1,
              32'h0009000B, 32'h000000A5, 1'b1, 1'b0, 1};
    vt[1] = '{3'd7, 5'd0,  16'h0000, 0,  20, 1'b1, 1'b0, 32'h000001FF, 1'b1,
              32'h0000700B, 32'h000001FF, 1'b1, 1'b0, 21};
    vt[2] = '{3'd2, 5'd5,  16'h1234, 0,  0,  1'b0, 1'b0, 32'hCAFEF00D, 1'b1,
              32'h091A228B, 32'h00000000, 1'b0, 1'b1, 16};
    vt[3] = '{3'd0, 5'd27, 16'hFFBA, 0,  0,  1'b1, 1'b0, 32'hDEADBEEF, 1'b0,
              32'h7FDD0D8B, 32'h00000000, 1'b0, 1'b0, 1};
    vt[4] = '{3'd5, 5'd31, 16'h8000, 0,  3,  1'b1, 1'b1, 32'h12345678, 1'b1,
              32'h40005F8B, 32'h12345678, 1'b1, 1'b0, 4};
    vt[5] = '{3'd1, 5'd1,  16'h0001, 15, 0,  1'b1, 1'b0, 32'h00000055, 1'b1,
              32'h0000908B, 32'h00000055, 1'b1, 1'b0, 16};
    vt[6] = '{3'd3, 5'd2,  16'h7FFF, 10, 1,  1'b0, 1'b0, 32'h00000077, 1'b1,
              32'h3FFFB10B, 32'h00000000, 1'b0, 1'b1, 27};

    // Reset state
    tick; tick;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
    chk("rst_insn", pcpi_insn, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick;

    for (int i = 0; i < 7; i++) do_txn(vt[i]);

    // Backpressure: one in flight, four queued, sixth refused
    for (int k = 0; k < 6; k++) begin
      cmd_valid  = 1'b1;
      cmd_funct3 = 3'(k);
      cmd_addr   = 5'(k);
      cmd_value  = 16'h0100 + 16'(k);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, (k < 5) ? 32'd1 : 32'd0);
      tick;
    end
    cmd_valid = 1'b0;
    chk("bp_busy", {31'd0, busy}, 32'd1);
    resp_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (j == 5) begin
        cmd_valid  = 1'b1;
        cmd_funct3 = 3'd5;
        cmd_addr   = 5'd5;
        cmd_value  = 16'h0105;
        chk("bp_sixth_ready", {31'd0, cmd_ready}, 32'd1);
        tick;
        cmd_valid = 1'b0;
      end
      n = 0;
      low = 0;
      while (!pcpi_valid && n < 50) begin
        n++;
        low++;
        tick;
      end
      if (j > 0) chk("bp_gap_ge1", {31'd0, (low >= 1)}, 32'd1);
      chk("bp_insn_order", pcpi_insn, enc(j));
      pcpi_ready = 1'b1;
      pcpi_wr    = 1'b1;
      pcpi_rd    = 32'h100 + 32'(j);
      tick;
      clear_pcpi();
      chk("bp_valid_drop", {31'd0, pcpi_valid}, 32'd0);
      chk("bp_resp_data", resp_data, 32'h100 + 32'(j));
      tick;
    end
    resp_ready = 1'b0;
    tick; tick;
    chk("bp_busy_end", {31'd0, busy}, 32'd0);

    // Reset in the middle of a request with two commands queued
    for (int k = 0; k < 3; k++) begin
      cmd_valid  = 1'b1;
      cmd_funct3 = 3'(k);
      cmd_addr   = 5'(k);
      cmd_value  = 16'h0100 + 16'(k);
      tick;
    end
    cmd_valid = 1'b0;
    chk("mr_pre_valid", {31'd0, pcpi_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    tick;
    chk("mr_valid", {31'd0, pcpi_valid}, 32'd0);
    chk("mr_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (pcpi_valid) n++;
    end
    chk("mr_no_stale_issue", n, 0);
    do_txn(vt[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
